branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters per entry.
- Looks up the current fetch PC combinationally and drives the predicted-taken flag and target into the fetch stage's prediction mux.
- Trained from execute with resolved branch outcomes.
- Registers its prediction alongside the IF/ID pipeline register so downstream stages can detect mispredicts.

Parameters:
- WIDTH, 32, address/data width.
- IDXW, 4, index bits; ENTRIES = 2**IDXW (16).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  WIDTH  current fetch PC (lookup address).
- branchpdans  output  1  predicted taken, combinational from pc.
- branchpdaddr  output  WIDTH  predicted target, combinational from pc.
- upd_valid  input  1  resolved-branch update strobe from execute.
- upd_pc  input  WIDTH  PC of the resolved branch.
- upd_taken  input  1  resolved direction.
- upd_target  input  WIDTH  resolved target.
- IFREGstall  input  1  hold IF/ID prediction registers.
- IFREGclear  input  1  zero IF/ID prediction registers.
- REGFpdans  output  1  registered branchpdans, aligned with REGFpc.
- REGFpdaddr  output  WIDTH  registered branchpdaddr.

Behaviour:
- Address split:
  - idx = pc[IDXW+1:2]; tag = pc[WIDTH-1:IDXW+2]; pc[1:0] ignored.
  - upd_pc splits the same way.
- Per-entry state: valid (1), tag, target[WIDTH-1:2], ctr (2 bits).
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == pc tag).
  - branchpdans = hit & ctr[idx][1].
  - branchpdaddr = {target[idx], 2'b00} on hit, else 0.
- Update (registered; visible to lookup the cycle after the edge):
  - upd_valid & entry hit: ctr saturating +1 if upd_taken, else saturating -1. If taken, target <= upd_target[WIDTH-1:2].
  - upd_valid & miss & upd_taken: allocate/overwrite the entry. valid=1, tag from upd_pc, target from upd_target, ctr=10.
  - upd_valid & miss & !upd_taken: no change.
  - An entry whose ctr reaches 00 stays valid.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-before-write); no bypass.
- IF/ID prediction registers (REGFpdans, REGFpdaddr):
  - Priority: reset > IFREGclear > IFREGstall > load.
  - Clear: load 0.
  - Stall: hold.
  - Otherwise: load branchpdans/branchpdaddr.
- Reset:
  - Every valid=0, ctr=01, tag=0, target=0.
  - REGFpdans=0, REGFpdaddr=0; combinational outputs therefore 0.
  - Reset overrides a concurrent upd_valid.
  - Reset mid-operation discards all training.
- No handshake/backpressure on the update port: one update per cycle, always accepted.

Decomposition:
- Shared package:
  - 2-bit counter encodings (SNT/WNT/WT/ST).
  - Counter allocate value (WT).
  - Default IDXW.
  - Helper constants for the index/tag bit positions.
- Sub-module bp_sat_ctr: 2-bit saturating counter next-state logic (inputs ctr, taken; output next ctr). Instantiated once, on the update index.
- Table storage stays as flop arrays in the top module; no RAM macro, so reset clears it in one cycle.

Test Plan:
- Reset, then lookup pc=0x100 -> branchpdans=0, branchpdaddr=0, REGFpdans=0 next cycle.
- upd pc=0x100 taken target=0x200; next cycle lookup 0x100 -> ans=1, addr=0x200 (ctr=10). One cycle later REGFpdans=1, REGFpdaddr=0x200.
- Counter walk on 0x100 from 10:
  - NT -> 01, ans=0; NT -> 00, ans=0; NT -> 00 (saturate, entry still hit, addr=0x200).
  - T -> 01, ans=0; T -> 10, ans=1; T, T -> 11 (saturate).
- Alias, IDXW=4: 0x140 shares idx 0 with 0x100.
  - Lookup 0x140 -> miss, ans=0.
  - NT update on 0x140 -> no change, 0x100 still hits.
  - T update 0x140->0x300 -> 0x140 hits (ans=1, addr=0x300); 0x100 now misses.
- Same-cycle: pc=0x180 lookup while upd 0x180 taken->0x400 -> this cycle ans=0; next cycle ans=1, addr=0x400.
- Pipe controls with branchpdans=1:
  - IFREGstall=1 while pc changes -> REGF outputs hold.
  - IFREGclear=1 with stall=1 -> REGF outputs 0.
  - reset asserted with upd_valid=1 -> table empty, the update is not applied.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared BTB definitions: counter encodings, default sizing, PC field positions.
// No logic, no latency, no backpressure.
package branch_predict_unit_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC    = CTR_WT;
    localparam ctr_e CTR_RESET    = CTR_WNT;
    localparam int   DEFAULT_IDXW = 4;

    // Instruction PCs are word aligned, so the index starts above the byte offset.
    localparam int IDX_LSB = 2;

    function automatic int tag_lsb(input int idxw);
        return idxw + IDX_LSB;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating direction counter next-state; purely combinational.
// Zero latency; no backpressure (evaluated every cycle).
module bp_sat_ctr
    import branch_predict_unit_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        case (ctr)
            CTR_SNT: ctr_nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_nxt = taken ? CTR_ST  : CTR_WT;
            default: ctr_nxt = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, one-cycle training, IF/ID prediction regs.
// Lookup zero latency, updates visible next cycle; update port always accepted, no backpressure.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDXW  = DEFAULT_IDXW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    output logic             branchpdans,
    output logic [WIDTH-1:0] branchpdaddr,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             IFREGstall,
    input  logic             IFREGclear,
    output logic             REGFpdans,
    output logic [WIDTH-1:0] REGFpdaddr
);

    localparam int ENTRIES = 2 ** IDXW;
    localparam int TAG_LSB = tag_lsb(IDXW);
    localparam int IDX_MSB = TAG_LSB - 1;
    localparam int TAGW    = WIDTH - TAG_LSB;
    localparam int TGTW    = WIDTH - IDX_LSB;

    logic            valid_q [ENTRIES];
    logic [TAGW-1:0] tag_q   [ENTRIES];
    logic [TGTW-1:0] tgt_q   [ENTRIES];
    ctr_e            ctr_q   [ENTRIES];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;
    ctr_e            up_ctr_nxt;

    // Byte-offset bits never participate in index, tag or target.
    logic unused_low_bits;
    assign unused_low_bits = ^{pc[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0], upd_target[IDX_LSB-1:0]};

    assign lk_idx = pc[IDX_MSB:IDX_LSB];
    assign lk_tag = pc[WIDTH-1:TAG_LSB];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign branchpdans  = lk_hit && ctr_q[lk_idx][1];
    assign branchpdaddr = lk_hit ? {tgt_q[lk_idx], 2'b00} : '0;

    assign up_idx = upd_pc[IDX_MSB:IDX_LSB];
    assign up_tag = upd_pc[WIDTH-1:TAG_LSB];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr     (ctr_q[up_idx]),
        .taken   (upd_taken),
        .ctr_nxt (up_ctr_nxt)
    );

    // Lookup reads the arrays directly, so a same-cycle update is seen only after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_nxt;
                if (upd_taken) begin
                    tgt_q[up_idx] <= upd_target[WIDTH-1:IDX_LSB];
                end
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= upd_target[WIDTH-1:IDX_LSB];
                ctr_q[up_idx]   <= CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || IFREGclear) begin
            REGFpdans  <= 1'b0;
            REGFpdaddr <= '0;
        end else if (!IFREGstall) begin
            REGFpdans  <= branchpdans;
            REGFpdaddr <= branchpdaddr;
        end
    end

endmodule
